// File: rtl/serv_dbg_ctrl_pkg.sv
// rtl/serv_dbg_ctrl_pkg.sv - debug sequencer state encoding and cause codes
package serv_dbg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_PEND   = 3'd1,
        ST_ENTER  = 3'd2,
        ST_HALTED = 3'd3,
        ST_RESUME = 3'd4,
        ST_STEP   = 3'd5
    } dbg_state_t;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    // The serial PC transfer states own the dpc shift path exclusively.
    function automatic logic is_xfer(dbg_state_t s);
        return (s == ST_ENTER) || (s == ST_RESUME);
    endfunction

endpackage

// File: rtl/serv_dbg_ctrl_if.sv
// rtl/serv_dbg_ctrl_if.sv - debug module <-> core halt/resume/reset handshake
interface serv_dbg_ctrl_if;

    logic haltreq;
    logic resumereq;
    logic ndmreset;
    logic halted;
    logic resumeack;
    logic dbg_reset;

    modport master (
        output haltreq,
        output resumereq,
        output ndmreset,
        input  halted,
        input  resumeack,
        input  dbg_reset
    );

    modport slave (
        input  haltreq,
        input  resumereq,
        input  ndmreset,
        output halted,
        output resumeack,
        output dbg_reset
    );

endinterface

// File: rtl/serv_dbg_dpc.sv
// rtl/serv_dbg_dpc.sv - 32-bit serial dpc shift register, LSB out
module serv_dbg_dpc (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_capture,
    input  logic i_rotate,
    input  logic i_write,
    input  logic i_din,
    output logic o_bit0
);

    logic [31:0] dpc;

    // Rotation keeps the value intact so a resume can be repeated later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dpc <= '0;
        end else if (i_rotate) begin
            dpc <= {dpc[0], dpc[31:1]};
        end else if (i_capture || i_write) begin
            dpc <= {i_din, dpc[31:1]};
        end
    end

    assign o_bit0 = dpc[0];

endmodule

// File: rtl/serv_dbg_ctrl.sv
// rtl/serv_dbg_ctrl.sv - debug-mode entry/exit sequencer for the bit-serial core
module serv_dbg_ctrl
    import serv_dbg_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    serv_dbg_ctrl_if.slave     dm,
    input  logic               i_cnt_done,
    input  logic               i_init,
    input  logic               i_ebreak,
    input  logic               i_dcsr_step,
    input  logic               i_dcsr_ebreakm,
    input  logic               i_pc_bit,
    input  logic               i_dpc_en,
    input  logic               i_csr_in,
    output logic               o_dpc_bit,
    output logic               o_pc_shift,
    output logic               o_pc_load,
    output logic               o_stall,
    output logic               o_dbg_halt,
    output logic [2:0]         o_cause
);

    dbg_state_t state;
    logic [4:0] cnt;
    logic [2:0] cause;

    logic retire;
    logic brk;
    logic cnt_last;
    logic in_enter;
    logic in_resume;
    logic in_halted;

    assign retire    = i_cnt_done & ~i_init;
    assign brk       = retire & i_ebreak & i_dcsr_ebreakm;
    assign cnt_last  = (cnt == 5'd31);
    assign in_enter  = (state == ST_ENTER);
    assign in_resume = (state == ST_RESUME);
    assign in_halted = (state == ST_HALTED);

    always_ff @(posedge i_clk) begin
        if (i_rst || dm.ndmreset) begin
            state <= ST_RUN;
            cnt   <= 5'd0;
            cause <= CAUSE_NONE;
        end else begin
            case (state)
                ST_RUN: begin
                    if (brk) begin
                        state <= ST_ENTER;
                        cause <= CAUSE_EBREAK;
                    end else if (dm.haltreq) begin
                        state <= ST_PEND;
                        cause <= CAUSE_HALTREQ;
                    end
                end
                ST_PEND: begin
                    if (retire) state <= ST_ENTER;
                end
                ST_ENTER: begin
                    cnt <= cnt + 5'd1;
                    if (cnt_last) state <= ST_HALTED;
                end
                ST_HALTED: begin
                    if (dm.resumereq) state <= ST_RESUME;
                end
                ST_RESUME: begin
                    cnt <= cnt + 5'd1;
                    if (cnt_last) begin
                        cause <= CAUSE_NONE;
                        state <= i_dcsr_step ? ST_STEP : ST_RUN;
                    end
                end
                ST_STEP: begin
                    // Step completion outranks any ebreak or haltreq seen alongside it.
                    if (retire) begin
                        state <= ST_ENTER;
                        cause <= CAUSE_STEP;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // A non-debug reset aborts any in-flight PC transfer without an ack.
    assign o_pc_shift   = (in_enter | in_resume) & ~dm.ndmreset;
    assign o_pc_load    = in_resume & ~dm.ndmreset;
    assign o_stall      = in_enter | in_halted | in_resume;
    assign o_dbg_halt   = (cause == CAUSE_HALTREQ) & (in_enter | in_halted);
    assign o_cause      = cause;
    assign dm.halted    = in_halted;
    assign dm.resumeack = in_resume & cnt_last & ~dm.ndmreset;
    assign dm.dbg_reset = dm.ndmreset & ~i_rst;

    serv_dbg_dpc u_dpc (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_capture (in_enter & ~dm.ndmreset),
        .i_rotate  (in_resume & ~dm.ndmreset),
        .i_write   (i_dpc_en & ~is_xfer(state)),
        .i_din     (in_enter ? i_pc_bit : i_csr_in),
        .o_bit0    (o_dpc_bit)
    );

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// tb/tb_serv_dbg_ctrl.sv - scoreboard bench for serv_dbg_ctrl
module tb_serv_dbg_ctrl;
    import serv_dbg_ctrl_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cnt_done, i_init, i_ebreak, i_dcsr_step, i_dcsr_ebreakm;
    logic        i_pc_bit, i_dpc_en, i_csr_in;
    logic        o_dpc_bit, o_pc_shift, o_pc_load, o_stall, o_dbg_halt;
    logic [2:0]  o_cause;

    serv_dbg_ctrl_if dm ();

    serv_dbg_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .dm             (dm),
        .i_cnt_done     (i_cnt_done),
        .i_init         (i_init),
        .i_ebreak       (i_ebreak),
        .i_dcsr_step    (i_dcsr_step),
        .i_dcsr_ebreakm (i_dcsr_ebreakm),
        .i_pc_bit       (i_pc_bit),
        .i_dpc_en       (i_dpc_en),
        .i_csr_in       (i_csr_in),
        .o_dpc_bit      (o_dpc_bit),
        .o_pc_shift     (o_pc_shift),
        .o_pc_load      (o_pc_load),
        .o_stall        (o_stall),
        .o_dbg_halt     (o_dbg_halt),
        .o_cause        (o_cause)
    );

    always #5 i_clk = ~i_clk;

    // Core PC model: rotates on o_pc_shift, takes o_dpc_bit at the MSB on o_pc_load.
    logic [31:0] pc_model = 32'd0;
    logic [31:0] pc_val   = 32'd0;
    logic        pc_set   = 1'b0;
    assign i_pc_bit = pc_model[0];

    always @(posedge i_clk) begin
        if (pc_set)          pc_model <= pc_val;
        else if (o_pc_shift) pc_model <= {(o_pc_load ? o_dpc_bit : pc_model[0]), pc_model[31:1]};
    end

    typedef struct {
        bit          is_ack;
        logic [2:0]  cause;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push_exp(input bit is_ack, input logic [2:0] cause, input logic [31:0] val);
        exp_t e;
        e.is_ack = is_ack;
        e.cause  = cause;
        e.val    = val;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_val = v;
        pc_set = 1'b1;
        step();
        pc_set = 1'b0;
    endtask

    task automatic retire_once(input logic brk);
        i_cnt_done = 1'b1;
        i_init     = 1'b0;
        i_ebreak   = brk;
        step();
        i_cnt_done = 1'b0;
        i_ebreak   = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!dm.halted && n < 100) begin
            step();
            n++;
        end
        chk(name, 32'(dm.halted), 32'd1);
    endtask

    task automatic swap_dpc(input logic [31:0] wr, output logic [31:0] rd);
        for (int i = 0; i < 32; i++) begin
            rd[i]    = o_dpc_bit;
            i_csr_in = wr[i];
            i_dpc_en = 1'b1;
            step();
        end
        i_dpc_en = 1'b0;
        i_csr_in = 1'b0;
    endtask

    task automatic do_resume(input logic [31:0] exp_pc, input logic stp);
        int n = 0;
        push_exp(1'b1, CAUSE_NONE, exp_pc);
        i_dcsr_step  = stp;
        dm.resumereq = 1'b1;
        while (!dm.resumeack && n < 100) begin
            step();
            n++;
            if (n == 1) chk("halted_falls", 32'(dm.halted), 32'd0);
        end
        dm.resumereq = 1'b0;
        chk("resume_latency", 32'(n), 32'd32);
        step();
        chk("resumed_pc", pc_model, exp_pc);
        chk("resumed_state", 32'({o_stall, o_cause, dm.halted}), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each halt entry and each resume ack.
    int          run_len  = 0;
    int          last_run = 0;
    logic [31:0] reload   = 32'd0;
    logic        halted_q = 1'b0;
    logic        ack_q    = 1'b0;

    always @(negedge i_clk) begin
        if (o_pc_shift) begin
            run_len++;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
        if (o_pc_load) reload = {o_dpc_bit, reload[31:1]};
        if (ack_q) chk("ack_width", 32'(dm.resumeack), 32'd0);
        if (dm.halted && !halted_q) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_halt: got halt entry expected none");
            end else begin
                me = q.pop_front();
                chk("halt_kind", 32'(me.is_ack), 32'd0);
                chk("halt_cause", 32'(o_cause), 32'(me.cause));
                chk("halt_dbg_halt", 32'(o_dbg_halt), 32'(me.cause == CAUSE_HALTREQ));
                chk("enter_len", 32'(last_run), 32'd32);
            end
        end
        if (dm.resumeack) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: got resumeack expected none");
            end else begin
                me = q.pop_front();
                chk("ack_kind", 32'(me.is_ack), 32'd1);
                chk("reload_dpc", reload, me.val);
                chk("resume_len", 32'(run_len), 32'd32);
            end
        end
        halted_q = dm.halted;
        ack_q    = dm.resumeack;
    end

    logic [31:0] got;

    initial begin
        i_rst = 1'b1;
        {i_cnt_done, i_init, i_ebreak, i_dcsr_step, i_dcsr_ebreakm, i_dpc_en, i_csr_in} = '0;
        dm.haltreq = 1'b0; dm.resumereq = 1'b0; dm.ndmreset = 1'b0;
        step(); step(); step();
        chk("reset_outputs", 32'({o_pc_shift, o_pc_load, o_stall, o_dbg_halt, o_cause,
                                  dm.halted, dm.resumeack, dm.dbg_reset, o_dpc_bit}), 32'd0);
        i_rst = 1'b0;
        step();
        swap_dpc(32'd0, got);
        chk("reset_dpc", got, 32'd0);

        // haltreq mid-instruction, PC 0x104
        set_pc(32'h0000_0104);
        dm.haltreq = 1'b1;
        step();
        dm.haltreq = 1'b0;
        chk("pend_cause", 32'(o_cause), 32'(CAUSE_HALTREQ));
        chk("pend_no_stall", 32'(o_stall), 32'd0);
        i_cnt_done = 1'b1; i_init = 1'b1;
        step();
        i_cnt_done = 1'b0; i_init = 1'b0;
        chk("init_no_retire", 32'(o_stall), 32'd0);
        step(); step();
        push_exp(1'b0, CAUSE_HALTREQ, 32'd0);
        retire_once(1'b0);
        repeat (31) step();
        chk("enter_not_halted", 32'(dm.halted), 32'd0);
        chk("enter_stall", 32'(o_stall), 32'd1);
        chk("enter_dbg_halt", 32'(o_dbg_halt), 32'd1);
        step();
        chk("halt_latency", 32'(dm.halted), 32'd1);
        set_pc(32'hFFFF_0000);
        do_resume(32'h0000_0104, 1'b0);

        // ebreak without ebreakm stays in RUN
        i_dcsr_ebreakm = 1'b0;
        retire_once(1'b1);
        step();
        chk("no_ebreakm_run", 32'({o_stall, o_cause}), 32'd0);

        // ebreak with ebreakm at PC 0x80, then CSR rewrite of dpc while halted
        set_pc(32'h0000_0080);
        i_dcsr_ebreakm = 1'b1;
        push_exp(1'b0, CAUSE_EBREAK, 32'd0);
        retire_once(1'b1);
        wait_halted("ebreak_halted");
        swap_dpc(32'hDEAD_BEEF, got);
        chk("ebreak_dpc", got, 32'h0000_0080);
        set_pc(32'd0);
        do_resume(32'hDEAD_BEEF, 1'b1);

        // single step with haltreq and ebreak also present
        set_pc(32'h0000_0204);
        dm.haltreq = 1'b1;
        push_exp(1'b0, CAUSE_STEP, 32'd0);
        retire_once(1'b1);
        dm.haltreq = 1'b0;
        wait_halted("step_halted");

        // ndmreset around RESUME cycle 10
        i_dcsr_step  = 1'b0;
        dm.resumereq = 1'b1;
        repeat (10) step();
        chk("resume_active", 32'(o_pc_load), 32'd1);
        dm.ndmreset  = 1'b1;
        dm.resumereq = 1'b0;
        #1;
        chk("ndm_dbg_reset", 32'(dm.dbg_reset), 32'd1);
        step();
        chk("ndm_run", 32'({o_stall, o_pc_shift, o_cause}), 32'd0);
        dm.haltreq = 1'b1;
        step(); step();
        chk("ndm_hold_run", 32'({o_stall, o_cause}), 32'd0);
        dm.ndmreset = 1'b0;
        step();
        dm.haltreq = 1'b0;
        chk("ndm_release_pend", 32'(o_cause), 32'(CAUSE_HALTREQ));
        chk("ndm_release_reset", 32'(dm.dbg_reset), 32'd0);
        set_pc(32'h0000_3000);
        push_exp(1'b0, CAUSE_HALTREQ, 32'd0);
        retire_once(1'b0);
        wait_halted("pend_after_ndm_halted");
        set_pc(32'd0);
        do_resume(32'h0000_3000, 1'b0);

        // i_rst mid-ENTER clears everything including a partial dpc
        set_pc(32'hFFFF_FFFF);
        retire_once(1'b1);
        repeat (10) step();
        i_rst = 1'b1;
        step();
        chk("rst_outputs", 32'({o_pc_shift, o_pc_load, o_stall, o_dbg_halt, o_cause,
                                dm.halted, dm.resumeack, dm.dbg_reset, o_dpc_bit}), 32'd0);
        i_rst = 1'b0;
        step();
        swap_dpc(32'd0, got);
        chk("rst_dpc", got, 32'd0);

        repeat (3) step();
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serv_dbg_ctrl.md
# serv_dbg_ctrl

Debug-mode sequencer for the bit-serial core. It decides when the core enters and leaves debug mode: external halt request, ebreak with dcsr.ebreakm set, or single-step completion. It owns the 32-bit serial dpc register and drives the halt/cause signals that the CSR unit encodes into dcsr.cause. It sits between the external debug module (DM) and the core's state/CSR logic, and gates instruction issue via a stall.

## Interface
- No parameters; XLEN fixed at 32.
- i_clk  in  1  clock
- i_rst  in  1  reset i_rst, synchronous, active-high; clock i_clk
- i_haltreq  in  1  DM halt request, level
- i_resumereq  in  1  DM resume request, level; held until o_resumeack
- i_ndmreset  in  1  DM non-debug-module reset request, level
- i_cnt_done  in  1  last cycle of the serial pass
- i_init  in  1  core in init (first) phase of a two-phase instruction
- i_ebreak  in  1  current instruction is ebreak
- i_dcsr_step  in  1  dcsr.step from CSR unit
- i_dcsr_ebreakm  in  1  dcsr.ebreakm from CSR unit
- i_pc_bit  in  1  serial PC bit, LSB first, valid during ENTER
- i_dpc_en  in  1  CSR access to dpc this cycle (shift enable)
- i_csr_in  in  1  serial CSR write data
- o_dpc_bit  out  1  dpc[0]; CSR read data and PC reload data
- o_pc_shift  out  1  core rotates PC one bit (ENTER, RESUME)
- o_pc_load  out  1  core loads o_dpc_bit into PC MSB (RESUME)
- o_stall  out  1  core must not start a new instruction
- o_dbg_halt  out  1  halt cause is haltreq (to CSR cause logic)
- o_cause  out  3  debug cause: 1 ebreak, 3 haltreq, 4 step, 0 none
- o_halted  out  1  core halted (to DM)
- o_resumeack  out  1  one-cycle resume acknowledge
- o_dbg_reset  out  1  core reset while i_ndmreset high

## Operation
- States:
  - RUN: normal execution.
  - PEND: a halt cause is latched; the current instruction is allowed to finish.
  - ENTER: 32-cycle capture of PC into dpc.
  - HALTED: core halted.
  - RESUME: 32-cycle reload of PC from dpc.
  - STEP: one instruction executing, then re-halt.
- Retire event R = i_cnt_done & !i_init.
- RUN -> PEND when i_haltreq is high; cause 3 is latched.
- RUN -> ENTER on R & i_ebreak & i_dcsr_ebreakm; cause 1. dpc = ebreak PC.
- PEND -> ENTER on R.
- STEP -> ENTER on R with cause 4. This applies even if haltreq or ebreak is also present (priority step > ebreak > haltreq).
- ENTER: a 5-bit counter runs 0..31. Each cycle: o_pc_shift=1 and dpc <= {i_pc_bit, dpc[31:1]}. At count 31 -> HALTED.
- HALTED: o_halted=1. On i_resumereq -> RESUME.
- RESUME: 32 cycles with o_pc_shift=1 and o_pc_load=1, o_dpc_bit driven. dpc rotates: dpc <= {dpc[0], dpc[31:1]}, so it is preserved.
  - At count 31: o_resumeack=1, o_cause cleared.
  - Next state is STEP if i_dcsr_step is high, else RUN.
- o_stall=1 in ENTER, HALTED and RESUME.
- o_dbg_halt=1 when o_cause==3 and state is ENTER or HALTED.
- dpc CSR access: when i_dpc_en is high and state is not ENTER or RESUME, dpc <= {i_csr_in, dpc[31:1]}. i_dpc_en is ignored in ENTER and RESUME.
- i_ndmreset:
  - While high: o_dbg_reset=1, state forced to RUN, counter and cause cleared, dpc kept.
  - On release: if i_haltreq is high, go directly to PEND.
- i_haltreq asserted during RESUME is ignored until RUN. The next cycle then goes to PEND.
- i_resumereq seen outside HALTED is ignored.

## Timing
- Reset values: state RUN, counter 0, dpc 0, o_cause 0. All outputs 0, with o_dpc_bit=0.
- Halt latency from an R cycle: ENTER occupies cycles R+1..R+32; o_halted rises at R+33.
- Resume latency from i_resumereq sampled high in HALTED at cycle t:
  - RESUME occupies cycles t+1..t+32.
  - o_resumeack is high in cycle t+32.
  - RUN or STEP begins at t+33.
- o_resumeack is exactly one cycle wide.
- o_halted falls in the first RESUME cycle.
- i_rst has priority over i_ndmreset. Either one, mid-ENTER or mid-RESUME, aborts the transfer with no ack.
- R while already in ENTER or RESUME cannot occur; o_stall prevents it.

## Structure
- Shared header serv_dbg_defs.vh holds:
  - state localparams (3-bit encoding);
  - cause codes CAUSE_NONE=0, CAUSE_EBREAK=1, CAUSE_HALTREQ=3, CAUSE_STEP=4.
- One sub-module, serv_dbg_dpc: a 32-bit serial shift register. Its inputs are capture, rotate and write enables plus a data-in bit; it outputs bit 0.
- The FSM and the 5-bit counter stay in serv_dbg_ctrl.

## Test plan
- Halt: i_haltreq=1 mid-instruction, PC=0x00000104 -> PEND until R, 32 ENTER cycles, o_halted=1, dpc=0x00000104, o_cause=3, o_dbg_halt=1.
- Ebreak: i_dcsr_ebreakm=1, ebreak retires at PC=0x80 -> o_cause=1, dpc=0x80. With ebreakm=0, the state stays RUN.
- Resume/step: halted with dpc=0x200 and i_dcsr_step=1, then i_resumereq -> PC reloaded 0x200 and o_resumeack at t+32. After one R: ENTER, o_cause=4, dpc = next PC.
- Priority: STEP with i_haltreq=1 and ebreak retiring -> o_cause=4.
- CSR write: halted, i_dpc_en for 32 cycles shifting 0xDEADBEEF -> the following resume reloads 0xDEADBEEF.
- Reset: i_ndmreset during RESUME cycle 10 -> o_dbg_reset=1, state RUN, no o_resumeack. i_rst mid-ENTER -> all outputs 0, dpc=0.
